// File: rtl/wisc_hazard_pkg.sv
// Shared types for the decode data-hazard unit: the scoreboard entry layout
// and the register-identifier width it is built around.
package wisc_hazard_pkg;

    localparam int REG_W    = 3;
    localparam int FWD_NONE = 0;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source identifier against every scoreboard entry and
// reports any hit, a load-use hit in stage 1, and the youngest hitting stage.
module hazard_match
    import wisc_hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int ELIG  = 2,
    parameter int SEL_W = 2
) (
    input  logic                  id_valid,
    input  logic                  src_valid,
    input  logic [REG_W-1:0]      src,
    input  sb_entry_t [DEPTH:1]   entries,
    output logic                  any_match,
    output logic                  load_use,
    output logic [SEL_W-1:0]      sel
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        any_match = 1'b0;
        load_use  = 1'b0;
        sel       = SEL_W'(FWD_NONE);
        // Walk oldest to youngest so the last hit written is the youngest stage.
        for (int k = DEPTH; k >= 1; k--) begin
            if (k <= ELIG && src_valid && id_valid &&
                entries[k].v && entries[k].rd == src) begin
                any_match = 1'b1;
                sel       = SEL_W'(k);
                if (k == 1) load_use = entries[1].ld;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: tracks in-flight destinations in a shift-register
// scoreboard and derives stall, forwarding selects, fire and a stall counter.
module hazard_scoreboard #(
    parameter int REG_W       = wisc_hazard_pkg::REG_W,
    parameter int DEPTH       = 3,
    parameter int FWD         = 1,
    parameter int RF_BYPASS   = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16,
    parameter int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rs_valid,
    input  logic             id_rt_valid,
    input  logic             id_rd_valid,
    input  logic             id_is_load,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic             id_fire,
    output logic [SEL_W-1:0] fwd_rs,
    output logic [SEL_W-1:0] fwd_rt,
    output logic [CNT_W-1:0] stall_count
);

    import wisc_hazard_pkg::*;

    localparam int ELIG = DEPTH - RF_BYPASS;

    sb_entry_t [DEPTH:1] entries;
    sb_entry_t [DEPTH:1] entries_nxt;

    logic             rs_any, rs_lu, rt_any, rt_lu;
    logic [SEL_W-1:0] rs_sel, rt_sel;

    hazard_match #(.DEPTH(DEPTH), .ELIG(ELIG), .SEL_W(SEL_W)) u_match_rs (
        .id_valid  (id_valid),
        .src_valid (id_rs_valid),
        .src       (id_rs),
        .entries   (entries),
        .any_match (rs_any),
        .load_use  (rs_lu),
        .sel       (rs_sel)
    );

    hazard_match #(.DEPTH(DEPTH), .ELIG(ELIG), .SEL_W(SEL_W)) u_match_rt (
        .id_valid  (id_valid),
        .src_valid (id_rt_valid),
        .src       (id_rt),
        .entries   (entries),
        .any_match (rt_any),
        .load_use  (rt_lu),
        .sel       (rt_sel)
    );

    always_comb begin
        stall  = 1'b0;
        fwd_rs = '0;
        fwd_rt = '0;
        if (FWD == 0) begin
            stall = rs_any | rt_any;
        end else begin
            // Only a load in stage 1 cannot be forwarded; selects are parked while stalled.
            stall = rs_lu | rt_lu;
            if (!stall) begin
                fwd_rs = rs_sel;
                fwd_rt = rt_sel;
            end
        end
    end

    assign id_fire = id_valid & ~stall & ~hold & ~flush;

    always_comb begin
        entries_nxt = entries;
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) entries_nxt[k] = entries[k-1];
            entries_nxt[1].v  = id_fire & id_rd_valid;
            entries_nxt[1].rd = id_rd;
            entries_nxt[1].ld = id_is_load;
        end
        // Flush clears the youngest stages after the shift, so it also works under hold.
        if (flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (k <= FLUSH_DEPTH) entries_nxt[k].v = 1'b0;
            end
        end
    end

    // NOTE: only the valid bits matter after reset, but the array is tiny, so
    // the whole entry is cleared rather than leaving rd/ld unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            entries <= entries_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && !hold && !flush && !(&stall_count)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: two hazard_scoreboard instances (forwarding, and
// stall-only with a narrow counter) driven in lockstep against a reference model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_rs_valid, id_rt_valid, id_rd_valid, id_is_load, hold, flush;
    logic [2:0] id_rs, id_rt, id_rd;

    logic        a_stall, a_fire, b_stall, b_fire;
    logic [1:0]  a_frs, a_frt, b_frs, b_frt;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .FWD(1), .RF_BYPASS(1), .FLUSH_DEPTH(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_rd_valid(id_rd_valid),
        .id_is_load(id_is_load), .hold(hold), .flush(flush),
        .stall(a_stall), .id_fire(a_fire), .fwd_rs(a_frs), .fwd_rt(a_frt),
        .stall_count(a_cnt)
    );

    hazard_scoreboard #(.DEPTH(3), .FWD(0), .RF_BYPASS(1), .FLUSH_DEPTH(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_rd_valid(id_rd_valid),
        .id_is_load(id_is_load), .hold(hold), .flush(flush),
        .stall(b_stall), .id_fire(b_fire), .fwd_rs(b_frs), .fwd_rt(b_frt),
        .stall_count(b_cnt)
    );

    typedef struct {bit v; bit [2:0] rd; bit ld;} ment_t;
    typedef struct {bit stall; bit fire; int frs; int frt; int cnt;} exp_t;

    ment_t ma[1:3];
    ment_t mb[1:3];
    int    cnt_a, cnt_b;
    exp_t  qa[$];
    exp_t  qb[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    obs_a_stall, obs_a_fire, obs_a_frs, obs_a_frt, obs_a_cnt;
    int    obs_b_stall, obs_b_fire, obs_b_cnt;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic exp_t predict(input bit use_b);
        ment_t e[1:3];
        bit    hs[1:2];
        bit    ht[1:2];
        exp_t  r;
        for (int k = 1; k <= 3; k++) begin
            if (use_b) e[k] = mb[k];
            else       e[k] = ma[k];
        end
        // Stage 3 is never eligible: the register file writes through.
        for (int k = 1; k <= 2; k++) begin
            hs[k] = id_valid && id_rs_valid && e[k].v && e[k].rd == id_rs;
            ht[k] = id_valid && id_rt_valid && e[k].v && e[k].rd == id_rt;
        end
        r.frs = 0;
        r.frt = 0;
        if (use_b) begin
            r.stall = hs[1] || hs[2] || ht[1] || ht[2];
            r.cnt   = cnt_b;
        end else begin
            r.stall = (hs[1] || ht[1]) && e[1].ld;
            r.cnt   = cnt_a;
            if (!r.stall) begin
                r.frs = hs[1] ? 1 : (hs[2] ? 2 : 0);
                r.frt = ht[1] ? 1 : (ht[2] ? 2 : 0);
            end
        end
        r.fire = id_valid && !r.stall && !hold && !flush;
        return r;
    endfunction

    function automatic void advance(input bit use_b, input bit st);
        ment_t e[1:3];
        bit    fire;
        for (int k = 1; k <= 3; k++) begin
            if (use_b) e[k] = mb[k];
            else       e[k] = ma[k];
        end
        fire = id_valid && !st && !hold && !flush;
        if (!hold) begin
            e[3]    = e[2];
            e[2]    = e[1];
            e[1].v  = fire && id_rd_valid;
            e[1].rd = id_rd;
            e[1].ld = id_is_load;
        end
        if (flush) e[1].v = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (use_b) mb[k] = e[k];
            else       ma[k] = e[k];
        end
        if (st && !hold && !flush) begin
            if (use_b && cnt_b < 15)     cnt_b++;
            if (!use_b && cnt_a < 65535) cnt_a++;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 1; k <= 3; k++) begin
            ma[k] = '{v: 1'b0, rd: 3'd0, ld: 1'b0};
            mb[k] = '{v: 1'b0, rd: 3'd0, ld: 1'b0};
        end
        cnt_a = 0;
        cnt_b = 0;
    endfunction

    // One decode cycle: expectations queued at drive, compared on the falling edge.
    task automatic step(input bit v, input int rs, input bit rsv, input int rt, input bit rtv,
                        input int rd, input bit rdv, input bit ld, input bit h, input bit f);
        exp_t ea, eb;
        id_valid = v;  id_rs = 3'(rs); id_rs_valid = rsv; id_rt = 3'(rt); id_rt_valid = rtv;
        id_rd = 3'(rd); id_rd_valid = rdv; id_is_load = ld; hold = h; flush = f;
        qa.push_back(predict(1'b0));
        qb.push_back(predict(1'b1));
        @(negedge clk);
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_stall", int'(a_stall), int'(ea.stall));
        check("a_fire",  int'(a_fire),  int'(ea.fire));
        check("a_fwd_rs", int'(a_frs),  ea.frs);
        check("a_fwd_rt", int'(a_frt),  ea.frt);
        check("a_count", int'(a_cnt),   ea.cnt);
        check("b_stall", int'(b_stall), int'(eb.stall));
        check("b_fire",  int'(b_fire),  int'(eb.fire));
        check("b_fwd_rs", int'(b_frs),  eb.frs);
        check("b_fwd_rt", int'(b_frt),  eb.frt);
        check("b_count", int'(b_cnt),   eb.cnt);
        obs_a_stall = a_stall; obs_a_fire = a_fire; obs_a_frs = a_frs; obs_a_frt = a_frt;
        obs_a_cnt = a_cnt; obs_b_stall = b_stall; obs_b_fire = b_fire; obs_b_cnt = b_cnt;
        @(posedge clk);
        advance(1'b0, ea.stall);
        advance(1'b1, eb.stall);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        id_valid = 0; id_rs_valid = 0; id_rt_valid = 0; id_rd_valid = 0;
        id_is_load = 0; hold = 0; flush = 0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_valid = 0; id_rt_valid = 0;
        id_rd_valid = 0; id_is_load = 0; hold = 0; flush = 0;
        #2;
        check("rst_a_stall", int'(a_stall), 0);
        check("rst_a_fwd",   int'(a_frs) + int'(a_frt), 0);
        check("rst_a_fire",  int'(a_fire), 1);
        check("rst_a_count", int'(a_cnt), 0);
        check("rst_b_fire",  int'(b_fire), 1);
        do_reset();

        // Load-use: one stall, then forward from stage 2.
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        step(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
        check("lu_stall", obs_a_stall, 1);
        step(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
        check("lu_release_stall", obs_a_stall, 0);
        check("lu_fwd_rs", obs_a_frs, 2);
        check("lu_fire", obs_a_fire, 1);
        check("lu_count", obs_a_cnt, 1);

        // ALU result forwarded from stage 1 to both sources.
        do_reset();
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
        check("alu_fwd_rt1", obs_a_frt, 1);
        check("alu_same_src", obs_a_frs, obs_a_frt);
        check("alu_no_stall", obs_a_stall, 0);

        do_reset();
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 4, 1, 0, 0, 0);
        check("alu_fwd_rt2", obs_a_frt, 2);

        do_reset();
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 4, 1, 0, 0, 0);
        check("alu_fwd_rt_rf", obs_a_frt, 0);

        // Stall-only instance: a stage-1 producer costs two cycles.
        do_reset();
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        step(1, 4, 1, 0, 0, 5, 1, 0, 0, 0);
        check("nofwd_stall1", obs_b_stall, 1);
        step(1, 4, 1, 0, 0, 5, 1, 0, 0, 0);
        check("nofwd_stall2", obs_b_stall, 1);
        step(1, 4, 1, 0, 0, 5, 1, 0, 0, 0);
        check("nofwd_fire", obs_b_fire, 1);
        check("nofwd_count", obs_b_cnt, 2);

        // Hold freezes a load-use stall; release costs one more cycle.
        do_reset();
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 0, 2, 1, 0, 1, 0);
            check("hold_stall", obs_a_stall, 1);
            check("hold_count", obs_a_cnt, 0);
        end
        step(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
        check("hold_rel_stall", obs_a_stall, 1);
        step(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
        check("hold_rel_fire", obs_a_fire, 1);
        check("hold_rel_count", obs_a_cnt, 1);

        // Flush kills the decode instruction; its Rd never becomes a hazard.
        do_reset();
        step(1, 0, 0, 0, 0, 3, 1, 1, 0, 1);
        check("flush_fire", obs_a_fire, 0);
        step(1, 3, 1, 3, 1, 4, 1, 0, 0, 0);
        check("flush_a_stall", obs_a_stall + obs_a_frs, 0);
        check("flush_b_stall", obs_b_stall, 0);

        // Source identifier matches but its valid flag is low.
        do_reset();
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0, 2, 1, 0, 0, 0);
        check("novalid_a", obs_a_stall, 0);
        check("novalid_b", obs_b_stall, 0);

        // Narrow counter saturates at all-ones.
        do_reset();
        for (int r = 0; r < 9; r++) begin
            step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
            for (int i = 0; i < 3; i++) step(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        idle();
        check("sat_count", obs_b_cnt, 15);

        // Asynchronous reset in the middle of a stall.
        do_reset();
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        step(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("mid_b_stall", int'(b_stall), 1);
        check("mid_b_count", int'(b_cnt), 1);
        rst_n = 1'b0;
        #1;
        check("arst_b_stall", int'(b_stall), 0);
        check("arst_b_count", int'(b_cnt), 0);
        check("arst_a_fire", int'(a_fire), 1);
        do_reset();

        // Randomised traffic against the model.
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the pipelined 16-bit core. It sits beside the decode stage and takes the per-instruction source and destination register identifiers with their valid bits, produced by the decode register-identifier logic. It tracks in-flight destination registers in a shift-register scoreboard, one entry per downstream stage. From that it produces the decode stall, per-source forwarding selects, the decode fire strobe and a saturating stall counter. Forwarding mode, pipeline depth and branch-flush depth are all configurable.

## Interface
- REG_W, 3, register-identifier width (8 GPRs)
- DEPTH, 3, tracked stages after decode (1 = EX … DEPTH = WB)
- FWD, 1, 1 = forwarding datapath present; 0 = stall-only
- RF_BYPASS, 1, 1 = register file writes through, so stage DEPTH never causes a hazard
- FLUSH_DEPTH, 1, youngest stages killed by flush (1..DEPTH)
- CNT_W, 16, stall-counter width
- SEL_W, $clog2(DEPTH+1), forwarding-select width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt, id_rd  in  REG_W  decoded identifiers
- id_rs_valid, id_rt_valid, id_rd_valid  in  1  identifier-used flags
- id_is_load  in  1  decode instruction is LD
- hold  in  1  whole back-end frozen (memory wait)
- flush  in  1  branch/jump redirect; kills younger work
- stall  out  1  decode must hold its instruction
- id_fire  out  1  instruction enters stage 1 this cycle
- fwd_rs, fwd_rt  out  SEL_W  0 = register file, k = forward from stage k
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Each scoreboard entry k (1..DEPTH) holds {v, rd, ld}.
- Source match for a source s at stage k: s_valid & id_valid & entry[k].v & entry[k].rd == s.
- Eligible stages are 1..DEPTH-RF_BYPASS.
- FWD=0:
  - stall when any source matches any eligible stage.
  - fwd_rs and fwd_rt are constant 0.
- FWD=1:
  - stall only on load-use: a source matches stage 1 and entry[1].ld = 1.
  - Otherwise fwd_x = the smallest k (youngest) with a match in an eligible stage; 0 if there is none.
  - While stall = 1, fwd_x = 0.
- id_fire = id_valid & ~stall & ~hold & ~flush.
- Shift, on every cycle with hold = 0: entry[k+1] ← entry[k]; entry[1] ← id_fire ? {id_rd_valid, id_rd, id_is_load} : bubble (v = 0).
- Flush clears v in entries 1..FLUSH_DEPTH after the shift is applied. It takes effect even when hold = 1, in which case no shift occurs and only the clear applies.
- flush has priority over id_fire; the decode instruction is also killed.
- stall_count increments when stall & ~hold & ~flush, and saturates at all-ones with no wrap.
- Stage DEPTH leaves the scoreboard on the next shift; nothing retires early.

## Timing
- stall, id_fire, fwd_rs and fwd_rt are combinational from the decode inputs and registered entries. Same-cycle response, no added latency.
- The scoreboard updates on the rising clk edge.
- A load-use stall lasts exactly 1 cycle when hold = 0.
- With FWD=0, a dependency on stage k lasts (DEPTH-RF_BYPASS-k+1) stall cycles.
- Reset, asynchronous on rst_n low: all entry v = 0, stall_count = 0. Outputs then read stall = 0, fwd_rs = fwd_rt = 0, id_fire = id_valid & ~hold & ~flush.
- Reset asserted mid-stall discards all in-flight entries immediately.
- A matching identifier with its valid flag low never causes a hazard.
- The same register in both Rs and Rt produces identical fwd_rs and fwd_rt.

## Structure
- Package wisc_hazard_pkg holds:
  - sb_entry_t struct {v, rd, ld}
  - REG_W
  - FWD_NONE = 0
- Sub-module hazard_match, instantiated twice (Rs, Rt):
  - compares one source against the entry array
  - returns any_match, load_use and the youngest-stage priority-encoded select
- The top level owns the entry shift register, flush clear, stall/fire logic and the counter.

## Test plan
- FWD=1, DEPTH=3: LD R1 issued, next decode ADD R2,R1,R3 → stall = 1 for 1 cycle, stall_count = 1; on the next cycle fwd_rs = 2, id_fire = 1.
- FWD=1: ADD R1 then dependent SUB using Rt = R1 → stall = 0, fwd_rt = 1. With one independent instruction between them → fwd_rt = 2. With two between them (RF_BYPASS=1) → fwd_rt = 0.
- FWD=0, DEPTH=3, RF_BYPASS=1: ADDI R4 followed by a reader of R4 → stall for 2 cycles, then id_fire; stall_count = 2.
- Stalled load-use with hold = 1 for 3 cycles → entries frozen, stall stays 1, stall_count unchanged; hold released → 1 further stall cycle.
- flush coincident with id_valid, FLUSH_DEPTH=1 → id_fire = 0, entry 1 invalid; a following reader of that Rd sees no hazard.
- Pre-load stall_count to 16'hFFFF via forced stalls → stays 16'hFFFF. Assert rst_n low mid-stall → stall = 0 and stall_count = 0 asynchronously.
